fill_rect: RTL and testbench
============================

# fill_rect

Parametrised rectangle-fill engine for the VGA adapter path. It is the successor to the lab 2 full-screen fill. On a start request it plots every pixel of a clipped rectangle, one pixel per clock, in column-major order. It supports four colour patterns and drives the adapter's `vga_x`/`vga_y`/`vga_colour`/`vga_plot` inputs directly, with a start/done handshake to the controlling FSM.

## Interface
- `SCREEN_W`, default 160: visible width in pixels.
- `SCREEN_H`, default 120: visible height in pixels.
- `X_W`, default 8: x coordinate width.
- `Y_W`, default 7: y coordinate width.
- `COLOUR_W`, default 3: colour width.

Ports (clock and reset first):
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: level request. Sampled only in IDLE and DONE.
- `x0`, `x1` input `X_W`: inclusive column bounds. Latched when a fill is accepted.
- `y0`, `y1` input `Y_W`: inclusive row bounds. Latched when a fill is accepted.
- `colour` input `COLOUR_W`: base colour. Latched when a fill is accepted.
- `mode` input 2: pattern select, latched when a fill is accepted. 0 = SOLID, 1 = COLSTRIPE, 2 = ROWSTRIPE, 3 = CHECKER.
- `busy` output 1: high in FILL.
- `done` output 1: high in DONE.
- `vga_x` output `X_W`: pixel column, registered.
- `vga_y` output `Y_W`: pixel row, registered.
- `vga_colour` output `COLOUR_W`: pixel colour, registered.
- `vga_plot` output 1: pixel write strobe, registered.

## Operation
- **States:** IDLE, FILL, DONE.
- **IDLE → FILL.** On `start`=1, latch the inputs and clip the rectangle.
  - Clip: `x1c = min(x1, SCREEN_W-1)` and `y1c = min(y1, SCREEN_H-1)`.
  - If the clipped rectangle is empty, go to DONE instead of FILL. Empty means any of: `x0 ≥ SCREEN_W`, `y0 ≥ SCREEN_H`, `x0 > x1c`, `y0 > y1c`.
- **FILL.** One pixel per cycle.
  - Scan order: x is the outer loop, y the inner loop. Start at (`x0`, `y0`). Increment y up to `y1c`, then reset y to `y0` and increment x.
  - The last pixel is (`x1c`, `y1c`); the next state is DONE.
  - Compare counters against `x1c`/`y1c` before incrementing, so a counter never wraps past its width, including at `x1c = 2^X_W - 1`.
- **Pattern colour** (truncated to `COLOUR_W`):
  - SOLID: `colour`.
  - COLSTRIPE: `x mod 2^COLOUR_W`.
  - ROWSTRIPE: `y mod 2^COLOUR_W`.
  - CHECKER: `colour` if `x[0]^y[0]` = 0, else `~colour`.
- **DONE.** `done`=1 and is held while `start`=1. When `start` drops to 0, return to IDLE. A new fill therefore requires `start` to go low and then high again.
- **`start` in FILL** is ignored; the latched parameters do not change.
- **Input changes** after acceptance have no effect.
- **Reset**, asserted in any state including mid-fill, gives at the next edge:
  - state IDLE;
  - `vga_plot`=0, `busy`=0, `done`=0;
  - `vga_x`=0, `vga_y`=0, `vga_colour`=0.
- **Outputs outside FILL:** `vga_plot` is 0. `vga_x`, `vga_y` and `vga_colour` hold their last values; they are don't-care to the adapter.

## Timing
- `start` sampled high at edge k (IDLE) → first pixel appears on the outputs after edge k+1, with `vga_plot`=1 and `busy`=1.
- N = `(x1c-x0+1)*(y1c-y0+1)` pixels occupy N consecutive cycles with no bubbles. `vga_plot` is high for exactly N cycles.
- `done` rises on the cycle immediately after the last plot cycle. `busy` falls on the same edge.
- Empty rectangle: `start` sampled at edge k → `done`=1 after edge k+1, with zero plot cycles.
- DONE → IDLE takes one edge after `start` is sampled low. `start` sampled high in IDLE is accepted immediately.

## Structure
- Package `fill_pkg` contains:
  - `fill_mode_e`: SOLID, COLSTRIPE, ROWSTRIPE, CHECKER.
  - `fill_state_e`: IDLE, FILL, DONE.
  - Default screen constants: 160, 120.
- Submodule `fill_pattern`: combinational (x, y, colour, mode) → pixel colour. It is instantiated once, and its output is registered into `vga_colour`.
- Top `fill_rect` holds:
  - the FSM;
  - the latched bounds and clip logic;
  - the x/y scan counters;
  - the output registers.

## Test plan
- **Full-screen SOLID.** (0,0)-(159,119), colour 5 → 19200 consecutive plots, all colour 5. First pixel (0,0), last (159,119). `done` the following cycle; pixel (1,0) follows (0,119).
- **COLSTRIPE.** (10,5)-(12,6) → exactly 6 plots, in order (10,5), (10,6), (11,5), (11,6), (12,5), (12,6), with colours 2, 2, 3, 3, 4, 4.
- **Clipping with CHECKER.** (150,110)-(255,127), colour 1 → 100 plots, last (159,119). Colour at (150,110) is 1; at (150,111) it is 6.
- **Empty rectangle.** x0=20, x1=10 → no `vga_plot`, `done`=1 one cycle after acceptance. Also check x0=200 → no plots, `done`=1.
- **Reset mid-fill.** `rst` asserted for 1 cycle during the 50th plot of a full-screen fill → `vga_plot`=0 and state IDLE next cycle. A following start refills from (x0,y0).
- **Handshake.** `start` held high through DONE → `done` stays 1 and no new fill starts. Pulse `start` during FILL → ignored. Drop `start`, then raise it → second fill accepted in exactly one cycle.

Source files
------------

// File: rtl/fill_pkg.sv
// Shared types and default screen geometry for the rectangle-fill engine.
package fill_pkg;

  typedef enum logic [1:0] {
    SOLID     = 2'd0,
    COLSTRIPE = 2'd1,
    ROWSTRIPE = 2'd2,
    CHECKER   = 2'd3
  } fill_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

endpackage

// File: rtl/fill_pattern.sv
// Combinational pattern generator: maps a pixel position to its fill colour.
module fill_pattern
  import fill_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [COLOUR_W-1:0] colour,
  input  fill_mode_e          mode,
  output logic [COLOUR_W-1:0] pix_colour
);

  // Select the pixel colour for the requested pattern
  always_comb begin
    pix_colour = colour;
    case (mode)
      SOLID:     pix_colour = colour;
      COLSTRIPE: pix_colour = COLOUR_W'(x);
      ROWSTRIPE: pix_colour = COLOUR_W'(y);
      CHECKER: begin
        if ((x[0] ^ y[0]) == 1'b1) begin
          pix_colour = ~colour;
        end else begin
          pix_colour = colour;
        end
      end
      default:   pix_colour = colour;
    endcase
  end

endmodule

// File: rtl/fill_rect.sv
// Rectangle-fill engine: plots a clipped rectangle one pixel per clock,
// column-major, driving the VGA adapter's plot inputs directly.
module fill_rect
  import fill_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y0,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [1:0]          mode,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  fill_state_e          state_q, state_d;
  // pend_q marks the cycle between accepting a request and the first pixel
  logic                 pend_q, pend_d;
  logic                 empty_q, empty_d;
  logic [X_W-1:0]       x0_q, x0_d, x1c_q, x1c_d;
  logic [Y_W-1:0]       y0_q, y0_d, y1c_q, y1c_d;
  logic [COLOUR_W-1:0]  colour_q, colour_d;
  fill_mode_e           mode_q, mode_d;
  logic [X_W-1:0]       vga_x_q, vga_x_d;
  logic [Y_W-1:0]       vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]  vga_colour_q, vga_colour_d;
  logic                 vga_plot_q, vga_plot_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [X_W-1:0]       x1c_s, nxt_x_s;
  logic [Y_W-1:0]       y1c_s, nxt_y_s;
  logic                 empty_s, last_s;
  logic [COLOUR_W-1:0]  pix_s;

  // Clip the requested rectangle to the screen and detect an empty result
  always_comb begin
    x1c_s   = (x1 > X_MAX) ? X_MAX : x1;
    y1c_s   = (y1 > Y_MAX) ? Y_MAX : y1;
    empty_s = (int'(x0) >= SCREEN_W) || (int'(y0) >= SCREEN_H) ||
              (x0 > x1c_s) || (y0 > y1c_s);
  end

  // Next scan position; the end test runs on the current pixel so nothing wraps
  always_comb begin
    last_s = (vga_x_q == x1c_q) && (vga_y_q == y1c_q);
    if (state_q == FILL) begin
      if (vga_y_q == y1c_q) begin
        nxt_x_s = vga_x_q + X_W'(1);
        nxt_y_s = y0_q;
      end else begin
        nxt_x_s = vga_x_q;
        nxt_y_s = vga_y_q + Y_W'(1);
      end
    end else begin
      nxt_x_s = x0_q;
      nxt_y_s = y0_q;
    end
  end

  fill_pattern #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .COLOUR_W (COLOUR_W)
  ) u_pattern (
    .x          (nxt_x_s),
    .y          (nxt_y_s),
    .colour     (colour_q),
    .mode       (mode_q),
    .pix_colour (pix_s)
  );

  // FSM next state, request latching and output register inputs
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    empty_d      = empty_q;
    x0_d         = x0_q;
    x1c_d        = x1c_q;
    y0_d         = y0_q;
    y1c_d        = y1c_q;
    colour_d     = colour_q;
    mode_d       = mode_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (empty_q) begin
            state_d = DONE;
          end else begin
            state_d      = FILL;
            vga_x_d      = nxt_x_s;
            vga_y_d      = nxt_y_s;
            vga_colour_d = pix_s;
            vga_plot_d   = 1'b1;
          end
        end else if (start) begin
          pend_d   = 1'b1;
          empty_d  = empty_s;
          x0_d     = x0;
          x1c_d    = x1c_s;
          y0_d     = y0;
          y1c_d    = y1c_s;
          colour_d = colour;
          mode_d   = fill_mode_e'(mode);
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          vga_x_d      = nxt_x_s;
          vga_y_d      = nxt_y_s;
          vga_colour_d = pix_s;
          vga_plot_d   = 1'b1;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = 1'b0;
      end
    endcase
    busy_d = (state_d == FILL);
    done_d = (state_d == DONE);
  end

  // State, latched request and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      empty_q      <= 1'b0;
      x0_q         <= '0;
      x1c_q        <= '0;
      y0_q         <= '0;
      y1c_q        <= '0;
      colour_q     <= '0;
      mode_q       <= SOLID;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      empty_q      <= empty_d;
      x0_q         <= x0_d;
      x1c_q        <= x1c_d;
      y0_q         <= y0_d;
      y1c_q        <= y1c_d;
      colour_q     <= colour_d;
      mode_q       <= mode_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_fill_rect.sv
// Self-checking bench for fill_rect: table of rectangles plus reset and
// handshake sequences, with a per-pixel scan/colour model.
module tb_fill_rect;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [2:0] colour;
  logic [1:0] mode;
  logic       busy, done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int checks = 0;
  int errors = 0;
  int cur_idx = 0;

  typedef struct {
    logic [7:0] x0; logic [7:0] x1; logic [6:0] y0; logic [6:0] y1;
    logic [2:0] colour; logic [1:0] mode; int n;
    logic [7:0] fx; logic [6:0] fy; logic [2:0] fc;
    logic [7:0] lx; logic [6:0] ly; logic [2:0] lc;
  } vec_t;

  vec_t vecs[9];

  fill_rect dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .colour(colour), .mode(mode),
    .busy(busy), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[vec %0d] actual=%0d expected=%0d", name, cur_idx, act, exp);
    end
  endtask

  function automatic logic [2:0] model_colour(input logic [7:0] x, input logic [6:0] y,
                                              input logic [2:0] c, input logic [1:0] m);
    case (m)
      2'd0:    return c;
      2'd1:    return x[2:0];
      2'd2:    return y[2:0];
      default: return ((x[0] ^ y[0]) == 1'b1) ? ~c : c;
    endcase
  endfunction

  // Run one fill with start held high; optionally pulse start low mid-fill.
  task automatic run_fill(input vec_t v, input bit pulse);
    int cyc, nplot, first_cyc, done_cyc, bad, bubble;
    bit seen_end;
    logic [7:0] ex, fx, lx;
    logic [6:0] ey, fy, ly, y1c_m;
    logic [2:0] fc, lc;
    cyc = 0; nplot = 0; first_cyc = -1; done_cyc = -1; bad = 0; bubble = 0;
    seen_end = 1'b0;
    fx = 8'd0; fy = 7'd0; fc = 3'd0; lx = 8'd0; ly = 7'd0; lc = 3'd0;
    y1c_m = (v.y1 > 7'd119) ? 7'd119 : v.y1;
    ex = v.x0; ey = v.y0;
    @(negedge clk);
    x0 = v.x0; x1 = v.x1; y0 = v.y0; y1 = v.y1; colour = v.colour; mode = v.mode;
    start = 1'b1;
    while (done_cyc < 0 && cyc < 25000) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (cyc == 1) begin
        x0 = 8'($urandom); x1 = 8'($urandom); y0 = 7'($urandom); y1 = 7'($urandom);
        colour = 3'($urandom); mode = 2'($urandom);
      end
      if (vga_plot) begin
        if (seen_end) bubble++;
        if (first_cyc < 0) begin
          first_cyc = cyc; fx = vga_x; fy = vga_y; fc = vga_colour;
        end
        if (vga_x !== ex || vga_y !== ey || vga_colour !== model_colour(ex, ey, v.colour, v.mode)
            || busy !== 1'b1)
          bad++;
        lx = vga_x; ly = vga_y; lc = vga_colour;
        nplot++;
        if (ey == y1c_m) begin
          ey = v.y0; ex = ex + 8'd1;
        end else begin
          ey = ey + 7'd1;
        end
      end else if (first_cyc >= 0) begin
        seen_end = 1'b1;
      end
      if (done) done_cyc = cyc;
      start = (pulse && nplot == 2) ? 1'b0 : 1'b1;
    end
    chk("plot_count", nplot, v.n);
    chk("done_cycle", done_cyc, 2 + v.n);
    chk("busy_at_done", int'(busy), 0);
    if (v.n > 0) begin
      chk("first_latency", first_cyc, 2);
      chk("first_pixel", int'({fx, fy, fc}), int'({v.fx, v.fy, v.fc}));
      chk("last_pixel", int'({lx, ly, lc}), int'({v.lx, v.ly, v.lc}));
      chk("pixel_seq_bad", bad, 0);
      chk("bubbles", bubble, 0);
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_done", int'({done, busy, vga_plot}), 4);
    end
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle_after_drop", int'({done, busy, vga_plot}), 0);
  endtask

  initial begin
    int nplot, cyc;
    //          x0     x1      y0     y1      col   mode  n      fx     fy      fc    lx      ly      lc
    vecs[0] = '{8'd0,   8'd159, 7'd0,   7'd119, 3'd5, 2'd0, 19200, 8'd0,   7'd0,   3'd5, 8'd159, 7'd119, 3'd5};
    vecs[1] = '{8'd10,  8'd12,  7'd5,   7'd6,   3'd0, 2'd1, 6,     8'd10,  7'd5,   3'd2, 8'd12,  7'd6,   3'd4};
    vecs[2] = '{8'd150, 8'd255, 7'd110, 7'd127, 3'd1, 2'd3, 100,   8'd150, 7'd110, 3'd1, 8'd159, 7'd119, 3'd1};
    vecs[3] = '{8'd20,  8'd10,  7'd0,   7'd5,   3'd3, 2'd0, 0,     8'd0,   7'd0,   3'd0, 8'd0,   7'd0,   3'd0};
    vecs[4] = '{8'd200, 8'd255, 7'd0,   7'd5,   3'd3, 2'd0, 0,     8'd0,   7'd0,   3'd0, 8'd0,   7'd0,   3'd0};
    vecs[5] = '{8'd3,   8'd4,   7'd100, 7'd119, 3'd0, 2'd2, 40,    8'd3,   7'd100, 3'd4, 8'd4,   7'd119, 3'd7};
    vecs[6] = '{8'd159, 8'd200, 7'd119, 7'd119, 3'd2, 2'd3, 1,     8'd159, 7'd119, 3'd2, 8'd159, 7'd119, 3'd2};
    vecs[7] = '{8'd5,   8'd9,   7'd119, 7'd50,  3'd1, 2'd0, 0,     8'd0,   7'd0,   3'd0, 8'd0,   7'd0,   3'd0};
    vecs[8] = '{8'd5,   8'd9,   7'd120, 7'd127, 3'd1, 2'd0, 0,     8'd0,   7'd0,   3'd0, 8'd0,   7'd0,   3'd0};

    rst = 1'b1; start = 1'b0;
    x0 = 8'd0; x1 = 8'd0; y0 = 7'd0; y1 = 7'd0; colour = 3'd0; mode = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", int'({vga_plot, busy, done, vga_x, vga_y, vga_colour}), 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle_after_reset", int'({vga_plot, busy, done}), 0);

    for (int i = 0; i < 9; i++) begin
      cur_idx = i;
      run_fill(vecs[i], (i == 5));
    end

    // Reset during the 50th plot of a full-screen fill, then refill.
    cur_idx = 100;
    @(negedge clk);
    x0 = vecs[0].x0; x1 = vecs[0].x1; y0 = vecs[0].y0; y1 = vecs[0].y1;
    colour = vecs[0].colour; mode = vecs[0].mode; start = 1'b1;
    nplot = 0; cyc = 0;
    while (nplot < 50 && cyc < 200) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (vga_plot) nplot++;
    end
    chk("rst_reach_50", nplot, 50);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_midfill_outputs", int'({vga_plot, busy, done, vga_x, vga_y, vga_colour}), 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_midfill_idle", int'({vga_plot, busy, done}), 0);
    cur_idx = 101;
    run_fill(vecs[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
